// File: rtl/input_conditioner_pkg.sv
// Shared constants for the switch/button front end and the control decoder that consumes it.
package input_conditioner_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned SIM_DEBOUNCE_CYCLES     = 8;

  localparam int unsigned MODE_MSB = 17;
  localparam int unsigned MODE_LSB = 16;
  localparam int unsigned MODE_W   = MODE_MSB - MODE_LSB + 1;

  localparam int unsigned KEY_CLK      = 0;
  localparam int unsigned KEY_RESETPC  = 1;
  localparam int unsigned KEY_RESETCPU = 2;
  localparam int unsigned KEY_BACK     = 3;

  typedef logic [MODE_W-1:0] mode_t;

  // Counter width able to hold DEBOUNCE_CYCLES-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One input bit: 2-flop synchronizer followed by a consecutive-cycle debounce filter.
module debounce_bit
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic        RESET_VAL       = 1'b0,
  parameter logic        INVERT          = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic level
);

  localparam int unsigned    CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          s;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          level_nxt;

  // Synchronizer idles at RESET_VAL so a released active-low key reads as not pressed.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      cnt   <= cnt_nxt;
      level <= level_nxt;
    end
  end

  assign s = sync2 ^ INVERT;

  // Any cycle agreeing with the stable value restarts the run; CNT_MAX commits the change.
  always_comb begin
    cnt_nxt   = '0;
    level_nxt = level;
    if (s != level) begin
      if (cnt == CNT_MAX) begin
        level_nxt = s;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Conditions raw push-buttons and slide switches into clean levels, press pulses and a mode-change pulse.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned NUM_SW          = 18
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] key_n_raw,
  input  logic [NUM_SW-1:0]   sw_raw,
  output logic [NUM_KEYS-1:0] keys,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_SW-1:0]   switches,
  output logic                mode_change
);

  logic [NUM_KEYS-1:0] keys_d;
  mode_t               mode_d;
  mode_t               mode_cur;

  // Keys are active-low on the board; the filter sees them active-high.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b1),
      .INVERT          (1'b1)
    ) u_db (
      .clock  (clock),
      .resetn (resetn),
      .raw    (key_n_raw[i]),
      .level  (keys[i])
    );
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b0),
      .INVERT          (1'b0)
    ) u_db (
      .clock  (clock),
      .resetn (resetn),
      .raw    (sw_raw[i]),
      .level  (switches[i])
    );
  end

  assign mode_cur = switches[MODE_MSB:MODE_LSB];

  // Pulses fire the cycle after the debounced level changes.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      keys_d      <= '0;
      key_press   <= '0;
      mode_d      <= '0;
      mode_change <= 1'b0;
    end else begin
      keys_d      <= keys;
      key_press   <= keys & ~keys_d;
      mode_d      <= mode_cur;
      mode_change <= (mode_cur != mode_d);
    end
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage between the board's raw slide switches and push-buttons and the CPU mode/control decoder.
- Each input bit passes through a 2-flop synchronizer and a per-bit debounce filter.
- Outputs are clean, active-high key levels, one-cycle key press pulses, debounced switch levels, and a one-cycle pulse on any change of the mode field (switches[17:16]).
- The decoder consumes only these conditioned signals and never sees raw pins.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synchronized input must differ from its stable value before the stable value updates (10 ms at 50 MHz). Legal range is 2 or more.
- NUM_KEYS, 4, number of push-buttons.
- NUM_SW, 18, number of slide switches.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  synchronous reset, active-low.
- key_n_raw  in  NUM_KEYS  raw push-buttons, active-low (0 = pressed), asynchronous to clock.
- sw_raw  in  NUM_SW  raw slide switches, asynchronous to clock.
- keys  out  NUM_KEYS  debounced key levels, active-high (1 = held).
- key_press  out  NUM_KEYS  one-cycle pulse when a key's debounced level goes 0->1.
- switches  out  NUM_SW  debounced switch levels.
- mode_change  out  1  one-cycle pulse when debounced switches[17:16] changes value.

Behaviour:
- Reset (resetn=0 at a rising edge):
  - Synchronizer flops load the released/idle value: key_n sync = 1, sw sync = 0.
  - All debounce counters clear to 0; stable values clear to 0.
  - keys, key_press, switches and mode_change are all 0.
  - Reset wins over every other event, including an in-progress count.
- Key inversion: key_n_raw is inverted at the synchronizer output. Inside the block every key bit is active-high.
- Per-bit filter, with s = synchronized bit, q = stable bit, c = counter of width clog2(DEBOUNCE_CYCLES):
  - If s == q: c <= 0.
  - If s != q and c < DEBOUNCE_CYCLES-1: c <= c+1.
  - If s != q and c == DEBOUNCE_CYCLES-1: q <= s and c <= 0.
  - Any single cycle with s == q restarts the count from 0. A bounce shorter than DEBOUNCE_CYCLES therefore never reaches the output.
  - The counter saturates by construction; it never wraps.
- Latency: a clean raw change held steady appears on keys/switches at rising edge DEBOUNCE_CYCLES+2 after the first edge that samples it. Exactly 10 edges for DEBOUNCE_CYCLES=8.
- key_press[i]:
  - Registered; asserted for exactly one cycle, the cycle after keys[i] rises.
  - Never asserted on release.
  - Never asserted twice without an intervening debounced release.
- mode_change:
  - Registered; asserted for one cycle, the cycle after switches[17:16] takes a new value.
  - If both bits change on different cycles, one pulse is produced per change.
- Independence: keys and switches filter independently. Simultaneous transitions on several bits each follow their own counter; no priority or coupling.
- Power-up: a switch already ON at reset release debounces to 1 after the normal latency and triggers mode_change if it is bit 16 or 17. No key_press is generated for keys not pressed.
- Reset asserted mid-count: the count is discarded and the output stays at its reset value.

Decomposition:
- Shared package holds:
  - DEFAULT_DEBOUNCE_CYCLES (500000) and SIM_DEBOUNCE_CYCLES (8).
  - MODE_MSB=17 and MODE_LSB=16, shared with the control decoder.
  - Key index constants: KEY_CLK=0, KEY_RESETPC=1, KEY_RESETCPU=2, KEY_BACK=3.
- One sub-module, debounce_bit:
  - Contents: 2-flop synchronizer, counter and stable register, with parameters DEBOUNCE_CYCLES and RESET_VAL.
  - Instantiated NUM_KEYS + NUM_SW times via generate.
  - Edge-detect and mode_change logic stay in the top level.

Test Plan (DEBOUNCE_CYCLES=8):
- Reset: resetn=0 for 3 cycles with key_n_raw=4'b0000 and sw_raw=all 1s -> all outputs 0 during reset. After release, keys=4'hF and switches=18'h3FFFF at edge 10, mode_change pulses once, key_press=4'hF for one cycle.
- Clean press: key_n_raw[0] 1->0 held 20 cycles -> keys[0]=1 exactly at edge 10, key_press[0] high exactly one cycle after that. Release -> keys[0]=0 at edge 10 with no pulse.
- Bounce rejection: key_n_raw[2] toggles low for 7 cycles, high for 1, low for 7 -> keys[2] stays 0 and key_press[2] never asserts. Then hold low for 8 cycles -> keys[2]=1.
- Mode change: sw_raw[17:16] 00->10 held -> switches[17:16]=2'b10 at edge 10 and mode_change pulses one cycle. Toggling sw_raw[5] alone -> no mode_change.
- Simultaneous: key_n_raw[1] and sw_raw[9] change on the same edge -> both outputs update on the same edge 10.
- Reset mid-count: sw_raw[3] set, resetn pulsed low at count 5 -> switches[3]=0. After reset release, switches[3]=1 at a fresh edge 10.
